sha256_stream_core: RTL and testbench

//  Parametrised multi-chunk SHA-256 engine with valid/ready handshakes on input and output.

---
 rtl/sha256_pkg.sv | 54 +++++
 rtl/sha256_compress.sv | 65 ++++++
 rtl/sha256_stream_core.sv | 135 +++++++++++++
 tb/tb_sha256_stream_core.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, round constants, initial hash value and round functions.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, ACC, DONE} state_t;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [255:0] IV_VEC = {IV[0], IV[1], IV[2], IV[3], IV[4], IV[5], IV[6], IV[7]};

  function automatic word_t rotr(word_t x, int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ch(word_t x, word_t y, word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(word_t x, word_t y, word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic word_t bsig0(word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ssig0(word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_compress.sv
// 64-round SHA-256 compression datapath: one round per cycle after a start pulse,
// with a 16-word sliding message schedule.
module sha256_compress
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [511:0] chunk,
  input  logic [255:0] h_in,
  output logic         done,
  output logic [255:0] vars
);

  word_t      w [0:15];
  word_t      a, b, c, d, e, f, g, h;
  word_t      t1, t2, w_next;
  logic [5:0] rnd;
  logic       busy;

  always_comb begin
    t1     = h + bsig1(e) + ch(e, f, g) + K[rnd] + w[0];
    t2     = bsig0(a) + maj(a, b, c);
    w_next = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
  end

  assign done = busy && (rnd == 6'd63);
  assign vars = {a, b, c, d, e, f, g, h};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      rnd  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      rnd  <= '0;
    end else if (busy) begin
      rnd <= rnd + 6'd1;
      if (rnd == 6'd63) busy <= 1'b0;
    end
  end

  // NOTE: the schedule window and working variables are pure datapath, always
  // loaded on start before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (start) begin
      for (int i = 0; i < 16; i++) w[i] <= chunk[511-32*i -: 32];
      {a, b, c, d, e, f, g, h} <= h_in;
    end else if (busy) begin
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_next;
      h <= g;
      g <= f;
      f <= e;
      e <= d + t1;
      d <= c;
      c <= b;
      b <= a;
      a <= t1 + t2;
    end
  end

endmodule

// File: rtl/sha256_stream_core.sv
// Multi-chunk SHA-256 / sha256d engine with valid/ready handshakes.
// Optional macro SHA256_MIDSTATE_EN adds in_use_mid/in_midstate to seed pass 1.
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int MAX_CHUNKS = 4,
  parameter int CNT_W      = $clog2(MAX_CHUNKS + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CNT_W-1:0]        in_num_chunks,
  input  logic [MAX_CHUNKS*512-1:0] in_data,
  input  logic                    in_double,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [255:0]            out_hash,
  output logic                    out_err
`ifdef SHA256_MIDSTATE_EN
  ,
  input  logic                    in_use_mid,
  input  logic [255:0]            in_midstate
`endif
);

  localparam int DATA_W = MAX_CHUNKS * 512;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  data_q;
  logic [CNT_W-1:0]   num_q, chunk_idx;
  logic               double_q, pass2_q;
  logic [255:0]       h_q, h_sum, h_start, vars;
  logic [511:0]       chunk_sel;
  logic               accept, num_ok, done, more_chunks, go_pass2;

  assign in_ready    = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign out_valid   = (state_q == DONE);
  assign accept      = in_valid && in_ready;
  assign num_ok      = (in_num_chunks != '0) && (in_num_chunks <= CNT_W'(MAX_CHUNKS));
  // Pass 2 always hashes a single block, whatever the message chunk count was.
  assign more_chunks = !pass2_q &&
                       ((CNT_W+1)'(chunk_idx) + (CNT_W+1)'(1) < (CNT_W+1)'(num_q));
  assign go_pass2    = !more_chunks && double_q && !pass2_q;

`ifdef SHA256_MIDSTATE_EN
  assign h_start = in_use_mid ? in_midstate : IV_VEC;
`else
  assign h_start = IV_VEC;
`endif

  always_comb begin
    for (int i = 0; i < 8; i++)
      h_sum[255-32*i -: 32] = h_q[255-32*i -: 32] + vars[255-32*i -: 32];
  end

  always_comb begin
    chunk_sel = data_q[DATA_W-1 -: 512];
    for (int i = 1; i < MAX_CHUNKS; i++)
      if (chunk_idx == CNT_W'(i)) chunk_sel = data_q[DATA_W-1-512*i -: 512];
  end

  sha256_compress u_compress (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (state_q == LOAD),
    .chunk   (chunk_sel),
    .h_in    (h_q),
    .done    (done),
    .vars    (vars)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d takes its hold value first so no path through the case
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = num_ok ? LOAD : DONE;
      LOAD:    state_d = ROUND;
      ROUND:   if (done) state_d = ACC;
      ACC:     state_d = (more_chunks || go_pass2) ? LOAD : DONE;
      DONE: begin
        if (accept)         state_d = num_ok ? LOAD : DONE;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_q     <= '0;
      chunk_idx <= '0;
      double_q  <= 1'b0;
      pass2_q   <= 1'b0;
      h_q       <= '0;
      out_hash  <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      num_q     <= in_num_chunks;
      double_q  <= in_double;
      chunk_idx <= '0;
      pass2_q   <= 1'b0;
      h_q       <= h_start;
      out_err   <= !num_ok;
      if (!num_ok) out_hash <= '0;
    end else if (state_q == ACC) begin
      if (more_chunks) begin
        chunk_idx <= chunk_idx + CNT_W'(1);
        h_q       <= h_sum;
      end else if (go_pass2) begin
        pass2_q   <= 1'b1;
        chunk_idx <= '0;
        h_q       <= IV_VEC;
      end else begin
        h_q      <= h_sum;
        out_hash <= h_sum;
      end
    end
  end

  // The second pass reuses chunk slot 0 to hold the padded first-pass digest.
  always_ff @(posedge clk) begin
    if (accept)
      data_q <= in_data;
    else if (state_q == ACC && go_pass2)
      data_q[DATA_W-1 -: 512] <= {h_sum, 1'b1, 191'b0, 64'd256};
  end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Directed bench for sha256_stream_core with a result scoreboard queue.
module tb_sha256_stream_core;

  localparam int MAX_CHUNKS = 4;
  localparam int CNT_W      = $clog2(MAX_CHUNKS + 1);
  localparam int DATA_W     = MAX_CHUNKS * 512;

  localparam logic [255:0] H_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] H_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] H_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] H_DBL   = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid, in_ready, in_double, out_valid, out_ready, out_err;
  logic [CNT_W-1:0]  in_num_chunks;
  logic [DATA_W-1:0] in_data;
  logic [255:0]      out_hash;
`ifdef SHA256_MIDSTATE_EN
  logic              in_use_mid;
  logic [255:0]      in_midstate;
`endif

  typedef struct {
    string        tag;
    logic [255:0] hash;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb [$];
  int   total  = 0;
  int   passed = 0;
  int   fails  = 0;

  logic [511:0]      blk_abc, blk_empty, blk_c0, blk_c1;
  logic [DATA_W-1:0] junk;

  always #5 clk = ~clk;

  sha256_stream_core #(.MAX_CHUNKS(MAX_CHUNKS)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_num_chunks (in_num_chunks),
    .in_data       (in_data),
    .in_double     (in_double),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_hash      (out_hash),
    .out_err       (out_err)
`ifdef SHA256_MIDSTATE_EN
    ,
    .in_use_mid    (in_use_mid),
    .in_midstate   (in_midstate)
`endif
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < DATA_W / 32; i++) in_data[32*i +: 32] = $urandom();
    in_num_chunks = CNT_W'($urandom());
    in_double     = 1'($urandom());
  endtask

  // Offer one message, wait (bounded) for acceptance, and record what it must produce.
  task automatic send(input string tag, input logic [DATA_W-1:0] data, input logic [CNT_W-1:0] n,
                      input logic dbl, input logic [255:0] exp_hash, input logic exp_err, input int exp_lat);
    int guard = 0;
    in_valid      = 1'b1;
    in_data       = data;
    in_num_chunks = n;
    in_double     = dbl;
    #1;
    while (!in_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " accept"}, in_ready, 1);
    sb.push_back('{tag, exp_hash, exp_err, exp_lat});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
  endtask

  // Wait (bounded) for out_valid, counting cycles from the accept cycle, then compare.
  task automatic wait_result();
    exp_t e;
    int   cyc = 1;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard: result expected but queue empty");
      $fatal(1);
    end
    e = sb.pop_front();
    @(negedge clk);
    while (!out_valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check({e.tag, " latency"}, cyc, e.lat);
    check({e.tag, " valid"}, out_valid, 1);
    check({e.tag, " hash"}, out_hash, e.hash);
    check({e.tag, " err"}, out_err, e.err);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " released"}, out_valid, 0);
  endtask

  initial begin
    blk_abc   = {32'h61626380, 416'h0, 64'd24};
    blk_empty = {32'h80000000, 480'h0};
    blk_c0    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    blk_c1    = {448'h0, 64'd448};
    for (int i = 0; i < DATA_W / 32; i++) junk[32*i +: 32] = $urandom();

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    scramble();
`ifdef SHA256_MIDSTATE_EN
    in_use_mid  = 1'b0;
    in_midstate = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_hash", out_hash, 0);
    check("reset out_err", out_err, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-chunk messages; unused chunk slots carry random junk.
    send("abc", {blk_abc, junk[DATA_W-513:0]}, 3'd1, 1'b0, H_ABC, 1'b0, 67);
    wait_result();
    release_out("abc");

    send("empty", {blk_empty, junk[DATA_W-513:0]}, 3'd1, 1'b0, H_EMPTY, 1'b0, 67);
    wait_result();
    release_out("empty");

    send("two_chunk", {blk_c0, blk_c1, junk[DATA_W-1025:0]}, 3'd2, 1'b0, H_TWO, 1'b0, 133);
    wait_result();
    release_out("two_chunk");

    send("abc_double", {blk_abc, junk[DATA_W-513:0]}, 3'd1, 1'b1, H_DBL, 1'b0, 133);
    wait_result();
    release_out("abc_double");

    // Illegal chunk counts at both ends of the range.
    send("count0", junk, 3'd0, 1'b0, 256'h0, 1'b1, 1);
    wait_result();
    release_out("count0");

    send("count5", junk, 3'd5, 1'b1, 256'h0, 1'b1, 1);
    wait_result();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold valid/err", {out_valid, out_err}, 2'b11);
      check("hold hash", out_hash, 256'h0);
    end

    // Output handshake and next accept in the same cycle.
    out_ready = 1'b1;
    send("b2b_abc", {blk_abc, junk[DATA_W-513:0]}, 3'd1, 1'b0, H_ABC, 1'b0, 67);
    out_ready = 1'b0;
    check("b2b busy", {out_valid, in_ready}, 2'b00);
    wait_result();
    release_out("b2b_abc");

    // Reset in the middle of ROUND aborts the work without emitting anything.
    send("abort", {blk_abc, junk[DATA_W-513:0]}, 3'd1, 1'b0, H_ABC, 1'b0, 67);
    repeat (20) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort in_ready", in_ready, 1);
    check("abort out_valid", out_valid, 0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send("post_reset_abc", {blk_abc, junk[DATA_W-513:0]}, 3'd1, 1'b0, H_ABC, 1'b0, 67);
    wait_result();
    release_out("post_reset_abc");

`ifdef SHA256_MIDSTATE_EN
    // Seed pass 1 with the state after chunk 0 of the two-chunk message, feed chunk 1 only.
    in_use_mid  = 1'b1;
    in_midstate = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
    send("midstate", {blk_c1, junk[DATA_W-513:0]}, 3'd1, 1'b0, H_TWO, 1'b0, 67);
    in_use_mid  = 1'b0;
    wait_result();
    release_out("midstate");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
